// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back buffer.
package wb_pkg;

  localparam int DEPTH    = 4;
  localparam int NUM_REGS = 14;
  localparam int DATA_W   = 8;

  typedef logic [3:0] reg_addr_t;

  // Pending-write record at the default data width.
  typedef struct packed {
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Register 0 is hard-wired and addresses at or above NUM_REGS do not exist.
  function automatic logic addr_writable(input reg_addr_t a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO: entry storage, wrapping head/tail pointers and occupancy.
// The whole array is exposed so the parent can do its own forwarding match.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int n     = 8,
  parameter  int DEPTH = wb_pkg::DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  reg_addr_t                 push_addr_i,
  input  logic [n-1:0]              push_data_i,
  output logic [PTR_W-1:0]          head_o,
  output logic [CNT_W-1:0]          count_o,
  output reg_addr_t [DEPTH-1:0]     addr_o,
  output logic [DEPTH-1:0][n-1:0]   data_o
);

  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  reg_addr_t [DEPTH-1:0]   addr_q;
  logic [DEPTH-1:0][n-1:0] data_q;

  // Next pointer/count state; flush wins over any push or pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) tail_d = tail_q + PTR_W'(1);
      if (pop_i)  head_d = head_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Control state with asynchronous clear; storage stays unreset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Write the new entry at the tail; contents are only meaningful while occupied.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  assign head_o  = head_q;
  assign count_o = cnt_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/wb_writer.sv
// Write-back buffer between execute and the register file, with operand
// forwarding from pending writes and a saturating count of discarded results.
module wb_writer
  import wb_pkg::*;
#(
  parameter  int n     = 8,
  parameter  int DEPTH = wb_pkg::DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  input  reg_addr_t    in_addr,
  input  logic [n-1:0] in_data,
  output logic         in_ready,
  input  logic         flush,
  input  logic         wr_hold,
  output logic         w,
  output reg_addr_t    wr_addr,
  output logic [n-1:0] Wdata,
  input  reg_addr_t    rd_addr1,
  input  reg_addr_t    rd_addr2,
  output logic         fwd_hit1,
  output logic         fwd_hit2,
  output logic [n-1:0] fwd_data1,
  output logic [n-1:0] fwd_data2,
  output logic [2:0]   count,
  output logic [7:0]   drop_cnt
);

  logic [PTR_W-1:0]        head;
  logic [CNT_W-1:0]        occ;
  reg_addr_t [DEPTH-1:0]   ent_addr;
  logic [DEPTH-1:0][n-1:0] ent_data;
  logic                    xfer, push, drop;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]        slot;

  // Ready depends only on occupancy and flush, never on in_valid.
  assign in_ready = (occ < CNT_W'(DEPTH)) && !flush;
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && addr_writable(in_addr);
  assign drop     = xfer && !addr_writable(in_addr);

  // Head entry goes straight to the register file port; a write pops it.
  assign w       = (occ != '0) && !wr_hold && !flush;
  assign wr_addr = ent_addr[head];
  assign Wdata   = ent_data[head];
  assign count   = 3'(occ);

  wb_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .push_i      (push),
    .pop_i       (w),
    .flush_i     (flush),
    .push_addr_i (in_addr),
    .push_data_i (in_data),
    .head_o      (head),
    .count_o     (occ),
    .addr_o      (ent_addr),
    .data_o      (ent_data)
  );

  // Scan oldest to newest so the newest match overwrites older ones.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    slot      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (!flush && (CNT_W'(i) < occ)) begin
        if ((rd_addr1 != '0) && (ent_addr[slot] == rd_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_data[slot];
        end
        if ((rd_addr2 != '0) && (ent_addr[slot] == rd_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_data[slot];
        end
      end
    end
  end

  // Saturating increment of the discarded-result counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Discard counter register; flush does not touch it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule
